// File: rtl/axi4_master.sv
// ---------------------------------------------------------------------------
// axi4_master
//
// Converts simple burst commands from a local client into AXI4 INCR bursts
// with a fixed 4-byte beat size. Only one command is in flight at a time. A
// burst that would cross a 4 KB page is refused before any AXI channel is
// touched.
//
// Ports
//   clk, rst                   single clock, asynchronous active-high reset
//   cmd_valid/cmd_write        command request (sampled only when idle), dir
//   cmd_addr/cmd_len           start byte address, beats minus one
//   busy                       command in progress, through the done cycle
//   wr_data/wr_ready           write beat from client / beat consumed pulse
//   rd_data/rd_valid           registered read beat to client
//   done/err                   completion pulse and its failure flag
//   aw*/w*/b*                  AXI4 write address, data and response channels
//   ar*/r*                     AXI4 read address and data channels
// ---------------------------------------------------------------------------
module axi4_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  output logic                  busy,

  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,

  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,

  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,

  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,

  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic                  arvalid,
  input  logic                  arready,

  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    R_ADDR,
    R_DATA
  } state_t;

  state_t                  state;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic                    err_acc;

  logic [ADDR_WIDTH-1:0]   cmd_addr_aligned;
  logic [12:0]             burst_end;
  logic                    crosses_4k;
  logic                    last_beat;
  logic                    r_beat_bad;

  // Beats are always 4 bytes, so the two low address bits are dropped
  // before the address is used anywhere (including the page check).
  assign cmd_addr_aligned = cmd_addr & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};

  // One byte past the end of the burst, measured from the start of the
  // 4 KB page. Thirteen bits hold the worst case (0xFFC + 256*4).
  always_comb begin
    burst_end  = {1'b0, cmd_addr_aligned[11:0]}
               + {2'b00, ({1'b0, cmd_len} + 9'd1), 2'b00};
    crosses_4k = (burst_end > 13'd4096);
  end

  // The beat counter is shared by both directions: it marks the beat that
  // must carry wlast on writes and the beat that must carry rlast on reads.
  // A read beat is bad if the slave flags an error or if rlast disagrees
  // with where the counter says the burst ends.
  always_comb begin
    last_beat  = (beat_cnt == len_q);
    r_beat_bad = (rresp != 2'b00) || (rlast != last_beat);
  end

  // The write data path is a straight pass-through of the client's current
  // beat; wvalid is only raised after the AW handshake, so gating on it
  // keeps wdata, wlast and wr_ready quiet outside the data phase and drops
  // them together with wvalid when reset hits mid-burst.
  assign wdata    = wvalid ? wr_data : '0;
  assign wlast    = wvalid && last_beat;
  assign wr_ready = wvalid && wready;

  // Main controller. Every handshake-visible output is a register so the
  // AXI valids cannot glitch and stay put until the slave takes them.
  // done/err/rd_valid are single-cycle pulses and default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      awaddr   <= '0;
      awlen    <= '0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      araddr   <= '0;
      arlen    <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cmd_valid) begin
            busy     <= 1'b1;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            err_acc  <= 1'b0;
            if (crosses_4k) begin
              // Refused: finish right away without touching the bus.
              done <= 1'b1;
              err  <= 1'b1;
            end else if (cmd_write) begin
              awaddr  <= cmd_addr_aligned;
              awlen   <= cmd_len;
              awvalid <= 1'b1;
              state   <= W_ADDR;
            end else begin
              araddr  <= cmd_addr_aligned;
              arlen   <= cmd_len;
              arvalid <= 1'b1;
              state   <= R_ADDR;
            end
          end
        end

        W_ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            state   <= W_DATA;
          end
        end

        W_DATA: begin
          if (wready) begin
            if (last_beat) begin
              wvalid   <= 1'b0;
              beat_cnt <= '0;
              bready   <= 1'b1;
              state    <= W_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end

        W_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            done   <= 1'b1;
            err    <= (bresp != 2'b00);
            state  <= IDLE;
          end
        end

        R_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R_DATA;
          end
        end

        R_DATA: begin
          if (rvalid) begin
            rd_data  <= rdata;
            rd_valid <= 1'b1;
            if (rlast) begin
              // The slave decides when the burst ends; any disagreement
              // with our own count has already been folded into r_beat_bad.
              rready   <= 1'b0;
              done     <= 1'b1;
              err      <= err_acc | r_beat_bad;
              err_acc  <= 1'b0;
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              err_acc  <= err_acc | r_beat_bad;
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_master
//
// Directed bench for axi4_master. The bench plays both the command client
// and a simple AXI slave, cycle by cycle from negedge to negedge, and checks
// addresses, beat data, wlast, rd_valid ordering and done/err outcomes
// against values worked out by hand for each vector.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi4_master;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          busy;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  int compared   = 0;
  int mismatched = 0;

  axi4_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .busy(busy),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case a task somehow stalls beyond its own cycle budget.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents one command for exactly one clock, returning at the negedge
  // after the accepting edge.
  task automatic applyStimulus(input logic write, input logic [15:0] addr,
                               input logic [7:0] len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Full write burst with an optional AW stall, optional wready toggling,
  // and a chosen write response. Beat n carries base+n.
  task automatic runWrite(input logic [15:0] addr, input logic [7:0] len,
                          input int aw_stall, input logic w_toggle,
                          input logic [1:0] resp, input logic [31:0] base,
                          input logic exp_err);
    int          beats;
    int          cyc;
    int          stall;
    logic        aw_seen;
    logic        got_done;
    logic [15:0] exp_addr;
    beats    = 0;
    cyc      = 0;
    stall    = aw_stall;
    aw_seen  = 1'b0;
    got_done = 1'b0;
    exp_addr = addr & 16'hFFFC;
    applyStimulus(1'b1, addr, len);
    checkOutput("wr_busy", 32'(busy), 32'd1);
    checkOutput("wr_awvalid", 32'(awvalid), 32'd1);
    checkOutput("wr_awaddr", 32'(awaddr), 32'(exp_addr));
    checkOutput("wr_awlen", 32'(awlen), 32'(len));
    while (!got_done && cyc < 200) begin
      awready = (stall == 0);
      wready  = w_toggle ? cyc[0] : 1'b1;
      wr_data = base + 32'(beats);
      bvalid  = bready;
      bresp   = resp;
      #1;
      checkOutput("w_before_aw", 32'(wvalid & ~aw_seen), 32'd0);
      if (awvalid) begin
        checkOutput("aw_stable_addr", 32'(awaddr), 32'(exp_addr));
        checkOutput("aw_stable_len", 32'(awlen), 32'(len));
        if (awready) aw_seen = 1'b1;
        else stall--;
      end
      if (wvalid) begin
        checkOutput("wr_ready", 32'(wr_ready), 32'(wready));
        if (wready) begin
          checkOutput("wdata", wdata, base + 32'(beats));
          checkOutput("wlast", 32'(wlast), 32'(beats == int'(len)));
          beats++;
        end
      end
      if (done) begin
        got_done = 1'b1;
        checkOutput("wr_err", 32'(err), 32'(exp_err));
        checkOutput("wr_done_busy", 32'(busy), 32'd1);
        checkOutput("wr_beats", 32'(beats), 32'(int'(len) + 1));
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("wr_finished", 32'(got_done), 32'd1);
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    #1;
    checkOutput("wr_after_busy", 32'(busy), 32'd0);
    checkOutput("wr_after_done", 32'(done), 32'd0);
  endtask

  // Full read burst. bad_beat selects the beat answered with SLVERR
  // (-1 for none); gaps inserts idle cycles between rvalid beats.
  task automatic runRead(input logic [15:0] addr, input logic [7:0] len,
                         input int bad_beat, input logic gaps,
                         input logic [31:0] base, input logic exp_err);
    int   sent;
    int   rcv;
    int   cyc;
    logic got_done;
    sent     = 0;
    rcv      = 0;
    cyc      = 0;
    got_done = 1'b0;
    applyStimulus(1'b0, addr, len);
    checkOutput("rd_busy", 32'(busy), 32'd1);
    checkOutput("rd_arvalid", 32'(arvalid), 32'd1);
    checkOutput("rd_araddr", 32'(araddr), 32'(addr & 16'hFFFC));
    checkOutput("rd_arlen", 32'(arlen), 32'(len));
    checkOutput("rd_no_awvalid", 32'(awvalid), 32'd0);
    while (!got_done && cyc < 200) begin
      arready = 1'b1;
      rvalid  = rready && (sent <= int'(len)) && !(gaps && cyc[0]);
      rdata   = base + 32'(sent);
      rlast   = (sent == int'(len));
      rresp   = (sent == bad_beat) ? 2'b10 : 2'b00;
      #1;
      if (rd_valid) begin
        checkOutput("rd_data", rd_data, base + 32'(rcv));
        rcv++;
        checkOutput("rd_done_with_last", 32'(done), 32'(rcv == int'(len) + 1));
      end
      if (done) begin
        got_done = 1'b1;
        checkOutput("rd_err", 32'(err), 32'(exp_err));
        checkOutput("rd_beats", 32'(rcv), 32'(int'(len) + 1));
      end
      if (rvalid && rready) sent++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("rd_finished", 32'(got_done), 32'd1);
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    #1;
    checkOutput("rd_after_busy", 32'(busy), 32'd0);
    checkOutput("rd_after_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  // A page-crossing command must finish with done+err one cycle after
  // acceptance and never raise an address valid.
  task automatic runReject(input logic write, input logic [15:0] addr,
                           input logic [7:0] len);
    applyStimulus(write, addr, len);
    checkOutput("rej_done", 32'(done), 32'd1);
    checkOutput("rej_err", 32'(err), 32'd1);
    checkOutput("rej_busy", 32'(busy), 32'd1);
    checkOutput("rej_awvalid", 32'(awvalid), 32'd0);
    checkOutput("rej_arvalid", 32'(arvalid), 32'd0);
    @(negedge clk);
    checkOutput("rej_after_done", 32'(done), 32'd0);
    checkOutput("rej_after_busy", 32'(busy), 32'd0);
    checkOutput("rej_after_awvalid", 32'(awvalid), 32'd0);
    checkOutput("rej_after_arvalid", 32'(arvalid), 32'd0);
  endtask

  // Reset asserted while the second write beat is on the bus.
  task automatic runResetMidBurst();
    int beats;
    int cyc;
    beats = 0;
    cyc   = 0;
    applyStimulus(1'b1, 16'h0100, 8'd3);
    awready = 1'b1;
    wready  = 1'b1;
    while (beats < 1 && cyc < 50) begin
      wr_data = 32'h5A + 32'(beats);
      #1;
      if (wvalid && wready) beats++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("mid_reached_beat2", 32'(beats), 32'd1);
    #1;
    checkOutput("mid_pre_wvalid", 32'(wvalid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_wvalid", 32'(wvalid), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_wlast", 32'(wlast), 32'd0);
    checkOutput("mid_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("mid_bready", 32'(bready), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    awready   = 1'b0;
    wready    = 1'b0;
    bresp     = 2'b00;
    bvalid    = 1'b0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
    checkOutput("rst_wvalid", 32'(wvalid), 32'd0);
    checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("rst_rready", 32'(rready), 32'd0);
    checkOutput("rst_bready", 32'(bready), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;

    // Basic 4-beat write and read at 0x0010.
    runWrite(16'h0010, 8'd3, 0, 1'b0, 2'b00, 32'hA0, 1'b0);
    runRead (16'h0010, 8'd3, -1, 1'b0, 32'hA0, 1'b0);

    // AW stalled five cycles, wready toggling every cycle.
    runWrite(16'h0040, 8'd5, 5, 1'b1, 2'b00, 32'hB0, 1'b0);

    // Page-crossing write refused; SLVERR on second read beat.
    runReject(1'b1, 16'h0FF8, 8'd3);
    runRead (16'h0020, 8'd3, 1, 1'b0, 32'hC0, 1'b1);

    // Bursts ending exactly on the page boundary are legal; one past is not.
    runWrite(16'h0FF0, 8'd3, 0, 1'b0, 2'b00, 32'hD0, 1'b0);
    runReject(1'b0, 16'h0FFC, 8'd1);

    // Unaligned single-beat read with rvalid gaps; write with SLVERR response.
    runRead (16'h0FFF, 8'd0, -1, 1'b1, 32'hE0, 1'b0);
    runWrite(16'h0080, 8'd1, 0, 1'b0, 2'b10, 32'hF0, 1'b1);

    // Reset mid-burst, then normal traffic again.
    runResetMidBurst();
    runWrite(16'h0200, 8'd2, 1, 1'b1, 2'b00, 32'h10, 1'b0);
    runRead (16'h0300, 8'd4, -1, 1'b1, 32'h20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi4_master.md
AXI4_MASTER -- requirements
Module: axi4_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (AXI size fixed at 4 bytes).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request, sampled only in IDLE.
REQ-006 SHALL have port cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port cmd_addr  input  ADDR_WIDTH  start byte address.
REQ-008 SHALL have port cmd_len  input  8  beats minus one (AXI LEN encoding).
REQ-009 SHALL have port busy  output  1  command in progress.
REQ-010 SHALL have port wr_data  input  DATA_WIDTH  current write beat data.
REQ-011 SHALL have port wr_ready  output  1  pulse: wr_data consumed this cycle; present next beat.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  registered read beat data.
REQ-013 SHALL have port rd_valid  output  1  rd_data valid, one cycle per beat.
REQ-014 SHALL have port done  output  1  one-cycle pulse at command completion.
REQ-015 SHALL have port err  output  1  valid with done: command failed.
REQ-016 SHALL have ports awaddr (output ADDR_WIDTH), awlen (output 8), awvalid (output 1), awready (input 1): AXI4 write-address channel.
REQ-017 SHALL have ports wdata (output DATA_WIDTH), wlast (output 1), wvalid (output 1), wready (input 1): AXI4 write-data channel.
REQ-018 SHALL have ports bresp (input 2), bvalid (input 1), bready (output 1): AXI4 write-response channel.
REQ-019 SHALL have ports araddr (output ADDR_WIDTH), arlen (output 8), arvalid (output 1), arready (input 1): AXI4 read-address channel.
REQ-020 SHALL have ports rdata (input DATA_WIDTH), rresp (input 2), rlast (input 1), rvalid (input 1), rready (output 1): AXI4 read-data channel.

Function
REQ-021 SHALL implement FSM states IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA; burst type INCR, size 4 bytes implied (not ported).
REQ-022 SHALL, in IDLE with cmd_valid=1, register addr (bits[1:0] forced to 0) and len and enter W_ADDR or R_ADDR next cycle; busy=1 from that cycle through the done cycle inclusive.
REQ-023 SHALL ignore cmd_valid whenever state != IDLE.
REQ-024 SHALL reject a command whose burst crosses a 4 KB boundary (addr[11:0] + (len+1)*4 > 4096): done=1, err=1 next cycle, no AXI valid asserted, return to IDLE.
REQ-025 SHALL hold awvalid/arvalid with stable awaddr/awlen/araddr/arlen until handshake, then move to W_DATA/R_DATA next cycle.
REQ-026 SHALL in W_DATA drive wvalid=1, wdata=wr_data combinationally, wr_ready=wvalid&wready, increment an 8-bit beat counter per handshake, wlast=1 only when counter==len; after last handshake enter W_RESP.
REQ-027 SHALL in W_RESP hold bready=1; on bvalid: done=1, err=(bresp!=2'b00), return to IDLE.
REQ-028 SHALL in R_DATA hold rready=1; per rvalid beat register rd_data=rdata, rd_valid=1 next cycle; err accumulates (sticky) any rresp!=2'b00 or rlast mismatch with counter==len.
REQ-029 SHALL complete a read on rvalid&rlast: last rd_valid and done (with accumulated err) in the same cycle, then IDLE.
REQ-030 SHALL never deassert a valid before its ready, and never assert wvalid before the AW handshake.

Reset
REQ-031 SHALL on rst=1 immediately force state=IDLE, counter=0, err accumulator=0, and all outputs (busy, wr_ready, rd_data, rd_valid, done, err, all *valid, wlast, bready, rready, addresses, lengths) to 0, including mid-burst.

Verification
REQ-032 Write addr=0x0010, len=3, wr_data 0xA0..0xA3, awready/wready always 1, bresp=00 -> awaddr=0x0010 awlen=3, 4 W beats, wlast on 4th, done=1 err=0.
REQ-033 Read addr=0x0010, len=3, slave returns 0xA0..0xA3 rlast on 4th -> rd_valid 4 cycles data 0xA0..0xA3 in order, done with last beat, err=0.
REQ-034 awready held 0 five cycles, wready toggling -> awvalid/awaddr stable, no wvalid before AW handshake, beats not dropped or duplicated.
REQ-035 Write addr=0x0FF8, len=3 -> done=1 err=1 one cycle after accept, no awvalid; read with rresp=10 on beat 2 -> done err=1.
REQ-036 rst=1 during W_DATA beat 2 -> wvalid, busy, wlast 0 immediately; next command after release runs normally.
